// File: rtl/udlx_pipeline_pkg.sv
// Shared pipeline definitions for the uDLX core: hazard FSM encodings and common constants.
package udlx_pipeline_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StLdStall = 2'd1,
        StBrFlush = 2'd2
    } hazard_state_e;

    localparam int unsigned ZeroReg         = 0;
    localparam int unsigned CntWidthDefault = 32;

endpackage

// File: rtl/udlx_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset; holds at all-ones.
module udlx_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// uDLX pipeline hazard controller: load-use bubbles and branch/jump squashes.
// Performance counters are built only when UDLX_HAZARD_PERF_EN is defined.
module hazard_ctrl
    import udlx_pipeline_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH  = 5,
    parameter int unsigned LOAD_USE_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES    = 1,
    parameter int unsigned CNT_WIDTH       = CntWidthDefault
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr2,
    input  logic                      ex_mem_data_rd_en,
    input  logic                      ex_reg_a_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] ex_reg_a_wr_addr,
    input  logic                      ex_branch_taken,
    input  logic                      ex_jump,
    output logic                      pc_stall,
    output logic                      if_id_stall,
    output logic                      if_id_flush,
    output logic                      id_ex_flush,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
);

    localparam logic [2:0] LuReload = 3'(LOAD_USE_CYCLES - 1);
    localparam logic [2:0] FlReload = 3'(FLUSH_CYCLES - 1);

    hazard_state_e state_q, state_d;
    logic [2:0]    remain_q, remain_d;
    logic          lu_hit, br_hit;
    logic          do_stall, do_flush;

    assign br_hit = ex_branch_taken | ex_jump;
    assign lu_hit = id_valid & ex_mem_data_rd_en & ex_reg_a_wr_en
                  & (ex_reg_a_wr_addr != REG_ADDR_WIDTH'(ZeroReg))
                  & ((ex_reg_a_wr_addr == id_rd_addr1) | (ex_reg_a_wr_addr == id_rd_addr2));

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        do_stall = 1'b0;
        do_flush = 1'b0;
        // A taken branch wins in every state and always restarts the squash count.
        if (br_hit) begin
            do_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d  = StBrFlush;
                remain_d = FlReload;
            end else begin
                state_d  = StRun;
                remain_d = 3'd0;
            end
        end else begin
            case (state_q)
                StRun: begin
                    if (lu_hit) begin
                        do_stall = 1'b1;
                        if (LOAD_USE_CYCLES > 1) begin
                            state_d  = StLdStall;
                            remain_d = LuReload;
                        end
                    end
                end
                StLdStall: begin
                    do_stall = 1'b1;
                    remain_d = remain_q - 3'd1;
                    if (remain_q == 3'd1) begin
                        state_d = StRun;
                    end
                end
                StBrFlush: begin
                    do_flush = 1'b1;
                    remain_d = remain_q - 3'd1;
                    if (remain_q == 3'd1) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d  = StRun;
                    remain_d = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StRun;
            remain_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    // Gating with rst_n keeps outputs quiet while reset is held, whatever the inputs.
    assign pc_stall    = rst_n & do_stall;
    assign if_id_stall = rst_n & do_stall;
    assign if_id_flush = rst_n & do_flush;
    assign id_ex_flush = rst_n & (do_stall | do_flush);

`ifdef UDLX_HAZARD_PERF_EN
    udlx_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_stall),
        .count (stall_cnt)
    );

    udlx_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (if_id_flush),
        .count (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
